// File: rtl/vend_payout_ctrl.sv
// vend_payout_ctrl: executes the vending FSM outcome.
// It runs the product motor, then ejects change coins one at a time,
// and waits for the hopper sensor to confirm each coin. If a coin is
// never confirmed, the block enters a sticky fault state.
module vend_payout_ctrl #(
   parameter int MOTOR_CYCLES  = 8,
   parameter int PULSE_CYCLES  = 2,
   parameter int SENSE_TIMEOUT = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req,
   input  logic       vend,
   input  logic [1:0] change,
   input  logic       coin_sense,
   output logic       motor_on,
   output logic       coin_kick,
   output logic       busy,
   output logic       done,
   output logic       fault,
   output logic [1:0] coins_paid
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_MOTOR = 3'd1;
   localparam logic [2:0] ST_KICK  = 3'd2;
   localparam logic [2:0] ST_WAIT  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;
   localparam logic [2:0] ST_FAULT = 3'd5;

   // One shared cycle counter serves the motor, kick and wait phases,
   // so it is sized for the longest of the three.
   localparam int CNT_MAX_MK = (MOTOR_CYCLES > PULSE_CYCLES) ? MOTOR_CYCLES : PULSE_CYCLES;
   localparam int CNT_MAX    = (CNT_MAX_MK > SENSE_TIMEOUT) ? CNT_MAX_MK : SENSE_TIMEOUT;
   localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] MOTOR_LAST = CNT_W'(MOTOR_CYCLES - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(SENSE_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       rem_q, rem_d;
   logic [1:0]       paid_q, paid_d;
   logic             motor_q, motor_d;
   logic             kick_q, kick_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             fault_q, fault_d;

   // Next-state, counter and coin bookkeeping for the payout sequence.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      paid_d  = paid_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               rem_d  = change;
               paid_d = 2'd0;
               cnt_d  = CNT_ZERO;
               if (vend) begin
                  state_d = ST_MOTOR;
               end else if (change != 2'd0) begin
                  state_d = ST_KICK;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MOTOR: begin
            if (cnt_q == MOTOR_LAST) begin
               cnt_d   = CNT_ZERO;
               state_d = (rem_q != 2'd0) ? ST_KICK : ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_KICK: begin
            if (cnt_q == PULSE_LAST) begin
               cnt_d   = CNT_ZERO;
               state_d = ST_WAIT;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_WAIT: begin
            // A sense on the last allowed cycle still counts: sense wins.
            if (coin_sense) begin
               cnt_d = CNT_ZERO;
               if (rem_q != 2'd0) begin
                  rem_d = rem_q - 2'd1;
               end else begin
                  rem_d = rem_q;
               end
               if (paid_q != 2'd3) begin
                  paid_d = paid_q + 2'd1;
               end else begin
                  paid_d = paid_q;
               end
               state_d = (rem_q > 2'd1) ? ST_KICK : ST_DONE;
            end else if (cnt_q == WAIT_LAST) begin
               cnt_d   = CNT_ZERO;
               state_d = ST_FAULT;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // Output values for the upcoming state, so outputs align with the state register.
   always_comb begin
      motor_d = (state_d == ST_MOTOR);
      kick_d  = (state_d == ST_KICK);
      done_d  = (state_d == ST_DONE);
      fault_d = (state_d == ST_FAULT);
      busy_d  = (state_d == ST_MOTOR) || (state_d == ST_KICK) ||
                (state_d == ST_WAIT)  || (state_d == ST_DONE);
   end

   // State, counters and registered outputs with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= CNT_ZERO;
         rem_q   <= 2'd0;
         paid_q  <= 2'd0;
         motor_q <= 1'b0;
         kick_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         paid_q  <= paid_d;
         motor_q <= motor_d;
         kick_q  <= kick_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         fault_q <= fault_d;
      end
   end

   assign motor_on   = motor_q;
   assign coin_kick  = kick_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign fault      = fault_q;
   assign coins_paid = paid_q;

endmodule

// File: tb/tb_vend_payout_ctrl.sv
// Self-checking bench for vend_payout_ctrl. It runs directed and randomized
// transactions against a timeline model that is built from the payout rules.
module tb_vend_payout_ctrl;

   localparam int M = 8;
   localparam int P = 2;
   localparam int T = 16;
   localparam int NC = 128;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       req = 1'b0;
   logic       vend = 1'b0;
   logic [1:0] change = 2'd0;
   logic       coin_sense = 1'b0;
   logic       motor_on, coin_kick, busy, done, fault;
   logic [1:0] coins_paid;

   int n_checks = 0;
   int n_fail   = 0;

   vend_payout_ctrl #(.MOTOR_CYCLES(M), .PULSE_CYCLES(P), .SENSE_TIMEOUT(T)) dut (
      .clock(clock), .reset(reset), .req(req), .vend(vend), .change(change),
      .coin_sense(coin_sense), .motor_on(motor_on), .coin_kick(coin_kick),
      .busy(busy), .done(done), .fault(fault), .coins_paid(coins_paid)
   );

   always #5 clock = ~clock;

   // Expected per-cycle timeline, indexed by cycle number after the request edge.
   bit         e_motor [NC];
   bit         e_kick  [NC];
   bit         e_busy  [NC];
   bit         e_done  [NC];
   bit         e_fault [NC];
   logic [1:0] e_paid  [NC];
   bit         s_sense [NC];
   bit         s_noise [NC];

   function automatic logic [6:0] obs_vec();
      return {motor_on, coin_kick, busy, done, fault, coins_paid};
   endfunction

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      req = 1'b0;
      coin_sense = 1'b0;
      @(negedge clock);
      reset = 1'b1;
   endtask

   // Run one transaction. It must be called at a negedge while the DUT is in IDLE.
   // A delay d (1..T) confirms the coin on WAIT cycle d. A delay of 0 means the
   // coin is never confirmed.
   task automatic run_txn(input logic v, input logic [1:0] ch, input int d0, input int d1,
                          input int d2, input bit noise, output bit faulted);
      int dl[3];
      int t;
      int fault_at;
      int len;
      int cnt;
      logic [6:0] ex;
      logic [6:0] ob;
      dl[0] = d0; dl[1] = d1; dl[2] = d2;
      for (int k = 0; k < NC; k++) begin
         e_motor[k] = 1'b0; e_kick[k] = 1'b0; e_busy[k] = 1'b0; e_done[k] = 1'b0;
         e_fault[k] = 1'b0; e_paid[k] = 2'd0; s_sense[k] = 1'b0; s_noise[k] = 1'b0;
      end
      faulted = 1'b0;
      fault_at = 0;
      t = 1;
      if (v) begin
         for (int j = 0; j < M; j++) begin e_motor[t+j] = 1'b1; s_noise[t+j] = 1'b1; end
         t += M;
      end
      for (int i = 0; i < int'(ch); i++) begin
         if (!faulted) begin
            for (int j = 0; j < P; j++) begin e_kick[t+j] = 1'b1; s_noise[t+j] = 1'b1; end
            t += P;
            if (dl[i] == 0) begin
               faulted = 1'b1;
               fault_at = t + T;
            end else begin
               s_sense[t + dl[i] - 1] = 1'b1;
               t += dl[i];
            end
         end
      end
      if (faulted) begin
         for (int k = 1; k < fault_at; k++) e_busy[k] = 1'b1;
         for (int k = fault_at; k < NC; k++) e_fault[k] = 1'b1;
         len = fault_at + 3;
      end else begin
         e_done[t] = 1'b1;
         for (int k = 1; k <= t; k++) e_busy[k] = 1'b1;
         len = t + 1;
      end
      cnt = 0;
      for (int k = 1; k < NC; k++) begin
         if (s_sense[k-1]) cnt++;
         e_paid[k] = 2'(cnt);
      end

      req = 1'b1; vend = v; change = ch; coin_sense = 1'b0;
      for (int k = 1; k <= len; k++) begin
         @(negedge clock);
         req    = (noise && k < len) ? 1'($urandom_range(0, 1)) : 1'b0;
         vend   = 1'($urandom_range(0, 1));
         change = 2'($urandom_range(0, 3));
         coin_sense = s_sense[k] | (noise & s_noise[k] & 1'($urandom_range(0, 1)));
         ex = {e_motor[k], e_kick[k], e_busy[k], e_done[k], e_fault[k], e_paid[k]};
         ob = obs_vec();
         n_checks++;
         if (ob !== ex) begin
            n_fail++;
            $display("FAIL txn(v=%0d ch=%0d) cycle %0d: {motor,kick,busy,done,fault,paid} got %b want %b",
                     v, ch, k, ob, ex);
         end
      end
      req = 1'b0;
      coin_sense = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req = 1'b1; vend = 1'b1; change = 2'd3;
      repeat (3) @(negedge clock);
      n_checks++;
      if (obs_vec() !== 7'd0) begin
         n_fail++;
         $display("FAIL reset_state: got %b want %b", obs_vec(), 7'd0);
      end
      req = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      n_checks++;
      if (obs_vec() !== 7'd0) begin
         n_fail++;
         $display("FAIL reset_release_idle: got %b want %b", obs_vec(), 7'd0);
      end
   endtask

   task automatic test_directed();
      bit f;
      run_txn(1'b1, 2'd0, 0, 0, 0, 1'b0, f);   // product only
      run_txn(1'b0, 2'd2, 2, 2, 0, 1'b0, f);   // change only, senses in cycles 4 and 8
      run_txn(1'b0, 2'd0, 0, 0, 0, 1'b0, f);   // empty request
      run_txn(1'b0, 2'd1, T, 0, 0, 1'b0, f);   // sense on the last allowed WAIT cycle
      run_txn(1'b1, 2'd3, 1, T, 3, 1'b0, f);   // all coins, boundary on the middle coin
   endtask

   task automatic test_ignored_stimulus();
      bit f;
      run_txn(1'b1, 2'd2, 3, 5, 0, 1'b1, f);
      run_txn(1'b1, 2'd3, 2, 1, 4, 1'b1, f);
   endtask

   task automatic test_timeout_fault();
      bit f;
      run_txn(1'b1, 2'd3, 1, 0, 0, 1'b1, f);
      n_checks++;
      if (f !== 1'b1) begin
         n_fail++;
         $display("FAIL fault_model: got %0d want 1", f);
      end
      req = 1'b1; vend = 1'b1; change = 2'd2;
      repeat (4) @(negedge clock);
      req = 1'b0;
      n_checks++;
      if (obs_vec() !== 7'b0000101) begin
         n_fail++;
         $display("FAIL fault_sticky: got %b want %b", obs_vec(), 7'b0000101);
      end
      do_reset();
      n_checks++;
      if (obs_vec() !== 7'd0) begin
         n_fail++;
         $display("FAIL fault_cleared_by_reset: got %b want %b", obs_vec(), 7'd0);
      end
   endtask

   task automatic test_reset_mid_op();
      bit f;
      req = 1'b1; vend = 1'b1; change = 2'd1;
      repeat (3) @(negedge clock);
      req = 1'b0;
      n_checks++;
      if (motor_on !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_op_motor: got motor=%b busy=%b want 1 1", motor_on, busy);
      end
      reset = 1'b0;
      @(negedge clock);
      n_checks++;
      if (obs_vec() !== 7'd0) begin
         n_fail++;
         $display("FAIL mid_op_reset: got %b want %b", obs_vec(), 7'd0);
      end
      reset = 1'b1;
      @(negedge clock);
      run_txn(1'b0, 2'd1, 1, 0, 0, 1'b0, f);
   endtask

   task automatic test_back_to_back();
      bit f;
      run_txn(1'b0, 2'd1, 4, 0, 0, 1'b0, f);
      run_txn(1'b1, 2'd1, 1, 0, 0, 1'b0, f);
      run_txn(1'b0, 2'd0, 0, 0, 0, 1'b0, f);
      run_txn(1'b0, 2'd3, 1, 1, 1, 1'b0, f);
   endtask

   task automatic test_random();
      bit f;
      int d[3];
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < 3; i++) begin
            d[i] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, T));
         end
         run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), d[0], d[1], d[2],
                 1'($urandom_range(0, 1)), f);
         if (f) do_reset();
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignored_stimulus();
      test_timeout_fault();
      test_reset_mid_op();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
